// File: rtl/addr_window_decoder.sv
// Data-memory window decoder: registers chip select, gated write enable and the
// window-relative address for the on-chip data RAM, one cycle after the bus address.
module addr_window_decoder #(
    parameter int unsigned             ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR   = 32'h0000_8F11,
    parameter int unsigned             WINDOW_SIZE = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              WE,
    output logic              CS,
    output logic              iWE,
    output logic [ADDR_W-1:0] iAddress
);

    // One extra bit so the inclusive upper bound cannot wrap past 2**ADDR_W.
    localparam logic [ADDR_W:0] LAST_ADDR =
        {1'b0, BASE_ADDR} + (ADDR_W+1)'(WINDOW_SIZE) - (ADDR_W+1)'(1);

    generate
        if (WINDOW_SIZE == 0) begin : g_bad_size
            $fatal(1, "addr_window_decoder: WINDOW_SIZE must be > 0");
        end
        if (LAST_ADDR[ADDR_W]) begin : g_bad_range
            $fatal(1, "addr_window_decoder: window extends past the address space");
        end
    endgenerate

    logic              w_hit;
    logic [ADDR_W-1:0] w_offset;

    logic              r_cs;
    logic              r_iwe;
    logic [ADDR_W-1:0] r_iaddr;

    assign w_hit    = ({1'b0, address} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, address} <= LAST_ADDR);
    assign w_offset = address - BASE_ADDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs    <= 1'b0;
            r_iwe   <= 1'b0;
            r_iaddr <= '0;
        end else begin
            r_cs    <= w_hit;
            r_iwe   <= w_hit & WE;
            r_iaddr <= w_hit ? w_offset : '0;
        end
    end

    assign CS       = r_cs;
    assign iWE      = r_iwe;
    assign iAddress = r_iaddr;

endmodule

// File: tb/tb_addr_window_decoder.sv
// Scoreboard bench for addr_window_decoder: expected outputs are queued when an
// address is driven and checked after the following rising edge.
module tb_addr_window_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic        WE;
    logic        CS;
    logic        iWE;
    logic [31:0] iAddress;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        cs;
        logic        iwe;
        logic [31:0] ia;
        string       name;
    } exp_t;

    exp_t sb[$];

    addr_window_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .WE       (WE),
        .CS       (CS),
        .iWE      (iWE),
        .iAddress (iAddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge and queue what the outputs must show after the next rise.
    task automatic drive(input logic [31:0] a, input logic we, input logic cs_e,
                         input logic iwe_e, input logic [31:0] ia_e, input string nm);
        exp_t e;
        @(negedge clk);
        address = a;
        WE      = we;
        e.cs = cs_e; e.iwe = iwe_e; e.ia = ia_e; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        address = 'x;
        WE      = 1'bx;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (CS !== 1'b0) begin
            bad++; $display("FAIL reset_cs got=%b want=0", CS);
        end
        total++;
        if (iWE !== 1'b0) begin
            bad++; $display("FAIL reset_iwe got=%b want=0", iWE);
        end
        total++;
        if (iAddress !== 32'h0) begin
            bad++; $display("FAIL reset_iaddr got=%h want=00000000", iAddress);
        end
        @(negedge clk);
        address = 32'h0;
        WE      = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] a_t [9] = '{32'h8F20, 32'h8F11, 32'h8F10, 32'h9310, 32'h9311,
                                32'h8F00, 32'h9320, 32'hFFFF_FFFF, 32'h9000};
        logic        w_t [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic        c_t [9] = '{1, 1, 0, 1, 0, 0, 0, 0, 1};
        logic        i_t [9] = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
        logic [31:0] o_t [9] = '{32'h0F, 32'h0, 32'h0, 32'h3FF, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'hEF};
        string       n_t [9] = '{"mid", "low_edge", "below_low", "high_edge", "above_high",
                                "out_8f00", "out_9320", "out_ffffffff", "read_9000"};
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            drive(a_t[k], w_t[k], c_t[k], i_t[k], o_t[k], n_t[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (CS !== e.cs) begin
                bad++; $display("FAIL %s_cs got=%b want=%b", e.name, CS, e.cs);
            end
            total++;
            if (iWE !== e.iwe) begin
                bad++; $display("FAIL %s_iwe got=%b want=%b", e.name, iWE, e.iwe);
            end
            total++;
            if (iAddress !== e.ia) begin
                bad++; $display("FAIL %s_iaddr got=%h want=%h", e.name, iAddress, e.ia);
            end
        end
    endtask

    // Consecutive cycles with addresses clustered around both window edges.
    task automatic test_back_to_back();
        logic [31:0] a;
        logic        we;
        logic        hit;
        exp_t        e;
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8F11 + $urandom_range(0, 8) - 4;
                1:       a = 32'h9310 + $urandom_range(0, 8) - 4;
                2:       a = 32'h8F11 + $urandom_range(0, 1023);
                default: a = $urandom;
            endcase
            we  = 1'($urandom_range(0, 1));
            hit = (a >= 32'h0000_8F11) && (a <= 32'h0000_9310);
            drive(a, we, hit, hit && we, hit ? a - 32'h0000_8F11 : 32'h0, "b2b");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (CS !== e.cs || iWE !== e.iwe || iAddress !== e.ia) begin
                bad++;
                $display("FAIL b2b addr=%h we=%b got cs=%b iwe=%b ia=%h want cs=%b iwe=%b ia=%h",
                         a, we, CS, iWE, iAddress, e.cs, e.iwe, e.ia);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(32'h8F20, 1'b1, 1'b1, 1'b1, 32'h0F, "pre_rst");
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (CS !== e.cs || iWE !== e.iwe || iAddress !== e.ia) begin
            bad++; $display("FAIL pre_rst got cs=%b iwe=%b ia=%h want 1 1 0000000f", CS, iWE, iAddress);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (CS !== 1'b0 || iWE !== 1'b0 || iAddress !== 32'h0) begin
            bad++; $display("FAIL async_rst got cs=%b iwe=%b ia=%h want 0 0 00000000", CS, iWE, iAddress);
        end
        @(posedge clk);
        #1;
        total++;
        if (CS !== 1'b0 || iWE !== 1'b0) begin
            bad++; $display("FAIL rst_hold got cs=%b iwe=%b want 0 0", CS, iWE);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        address = 32'h9310;
        WE      = 1'b1;
        #3;
        total++;
        if (CS !== 1'b0 || iWE !== 1'b0 || iAddress !== 32'h0) begin
            bad++; $display("FAIL post_release got cs=%b iwe=%b ia=%h want 0 0 00000000", CS, iWE, iAddress);
        end
        @(posedge clk);
        #1;
        total++;
        if (CS !== 1'b1 || iWE !== 1'b1 || iAddress !== 32'h3FF) begin
            bad++; $display("FAIL first_edge got cs=%b iwe=%b ia=%h want 1 1 000003ff", CS, iWE, iAddress);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
